// File: rtl/msk_rnd_source.sv
// msk_rnd_source: seeded 128-bit LFSR streaming NRND random bits per valid/ready handshake.
// Optional zero-state health monitor enabled by defining MSK_RND_HEALTH_EN.
module msk_rnd_source #(
    parameter int NRND   = 8,
    parameter int WARMUP = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [127:0]    seed,
    input  logic            seed_valid,
    output logic [NRND-1:0] rnd_out,
    output logic            rnd_valid,
    input  logic            rnd_ready,
    output logic            health_err
);
    typedef enum logic [1:0] {ST_UNSEEDED, ST_WARM, ST_RUN} fsm_t;
    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d, adv;
    logic [7:0]   cnt_q, cnt_d;
    logic         frz;
`ifdef MSK_RND_HEALTH_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | (seed_valid && seed == '0) | (fsm_q != ST_UNSEEDED && state_q == '0);
    assign frz = err_q;
`else
    assign frz = 1'b0;
`endif
    assign health_err = frz;
    assign rnd_valid  = (fsm_q == ST_RUN) && !frz;
    assign rnd_out    = state_q[NRND-1:0];
    always_comb begin
        adv = state_q;
        for (int i = 0; i < NRND; i++)
            adv = {adv[126:0], adv[127] ^ adv[125] ^ adv[100] ^ adv[98]};
    end
    // Seed load takes priority over warm-up and handshake advances
    always_comb begin
        state_d = state_q;
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        if (!frz) begin
            if (seed_valid) begin
                state_d = (seed == '0) ? 128'h1 : seed;
                cnt_d   = 8'd0;
                fsm_d   = ST_WARM;
            end else if (fsm_q == ST_WARM) begin
                state_d = adv;
                cnt_d   = cnt_q + 8'd1;
                fsm_d   = (cnt_q == 8'(WARMUP - 1)) ? ST_RUN : ST_WARM;
            end else if (fsm_q == ST_RUN && rnd_ready) begin
                state_d = adv;
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= 128'h1;
            fsm_q   <= ST_UNSEEDED;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
        end
endmodule

// File: tb/tb_msk_rnd_source.sv
// tb_msk_rnd_source: randomized check of msk_rnd_source against a bit-sequence LFSR model.
module tb_msk_rnd_source;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int errs = 0;
    int checks = 0;
    logic [127:0] a_seed = '0, b_seed = '0, c_seed = '0;
    logic a_sv = 0, a_rdy = 0, b_sv = 0, b_rdy = 0, c_sv = 0, c_rdy = 0;
    logic [7:0] a_out, c_out;
    logic       b_out;
    logic a_vld, a_err, b_vld, b_err, c_vld, c_err;
    msk_rnd_source #(.NRND(8), .WARMUP(W)) u_a (.clk(clk), .rst(rst), .seed(a_seed), .seed_valid(a_sv),
        .rnd_out(a_out), .rnd_valid(a_vld), .rnd_ready(a_rdy), .health_err(a_err));
    msk_rnd_source #(.NRND(1), .WARMUP(1)) u_b (.clk(clk), .rst(rst), .seed(b_seed), .seed_valid(b_sv),
        .rnd_out(b_out), .rnd_valid(b_vld), .rnd_ready(b_rdy), .health_err(b_err));
    msk_rnd_source #(.NRND(8), .WARMUP(1)) u_c (.clk(clk), .rst(rst), .seed(c_seed), .seed_valid(c_sv),
        .rnd_out(c_out), .rnd_valid(c_vld), .rnd_ready(c_rdy), .health_err(c_err));
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Model: bit sequence x[n] = x[n-128]^x[n-126]^x[n-101]^x[n-99]; newest bit is rnd_out[0]
    bit mq[$];
    int m_left = 0;
    bit m_run = 0;
    bit m_err = 0;
    function automatic void m_load(input logic [127:0] s);
        mq.delete();
        for (int k = 127; k >= 0; k--) mq.push_back(s[k]);
    endfunction
    function automatic void m_adv();
        int n;
        for (int i = 0; i < 8; i++) begin
            n = mq.size();
            mq.push_back(mq[n-128] ^ mq[n-126] ^ mq[n-101] ^ mq[n-99]);
            void'(mq.pop_front());
        end
    endfunction
    function automatic logic [7:0] m_word();
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = mq[127-i];
        return w;
    endfunction
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic a_cycle(input bit sv, input logic [127:0] sd, input bit rdy, output bit hs);
        @(negedge clk);
        check("a_valid", a_vld, m_run && !m_err);
        if (m_run && !m_err) check("a_word", a_out, m_word());
        check("a_herr", a_err, m_err);
        a_sv = sv; a_seed = sd; a_rdy = rdy;
        hs = m_run && !m_err && rdy && !sv;
        if (m_err) begin
        end else if (sv) begin
`ifdef MSK_RND_HEALTH_EN
            if (sd == '0) m_err = 1;
`endif
            m_load(sd == '0 ? 128'h1 : sd);
            m_left = W;
            m_run = 0;
        end else if (m_left > 0) begin
            m_adv();
            m_left--;
            if (m_left == 0) m_run = 1;
        end else if (m_run && rdy) m_adv();
    endtask
    initial begin
        bit hs;
        int n_hs;
        logic [7:0] held;
        repeat (2) @(negedge clk);
        check("rst_a_valid", a_vld, 0);
        check("rst_a_herr", a_err, 0);
        check("rst_b_valid", b_vld, 0);
        check("rst_c_valid", c_vld, 0);
        rst = 0;
        repeat (3) a_cycle(0, '0, 1, hs);
        // Directed: NRND=1/WARMUP=1 and NRND=8/WARMUP=1
        @(negedge clk);
        b_sv = 1; b_seed = 128'h1 << 127; c_sv = 1; c_seed = 128'hA5;
        @(negedge clk);
        b_sv = 0; c_sv = 0;
        check("b_valid_warm", b_vld, 0);
        check("c_valid_warm", c_vld, 0);
        @(negedge clk);
        check("b_valid_run", b_vld, 1);
        check("b_word0", b_out, 1);
        check("c_valid_run", c_vld, 1);
        check("c_word0", c_out, 8'h00);
        @(negedge clk);
        check("b_word_hold", b_out, 1);
        b_rdy = 1; c_rdy = 1;
        @(negedge clk);
        b_rdy = 0; c_rdy = 0;
        check("b_word1", b_out, 0);
        check("c_word1", c_out, 8'h00);
        check("c_valid1", c_vld, 1);
        // Random stream with a 10-cycle stall
        a_cycle(1, rnd128(), 0, hs);
        n_hs = 0;
        for (int it = 0; it < 5000 && n_hs < 1000; it++) begin
            a_cycle(0, '0, ($urandom_range(0, 3) != 0), hs);
            if (hs) n_hs++;
            if (n_hs == 200 && hs) begin
                a_cycle(0, '0, 0, hs);
                held = a_out;
                for (int j = 0; j < 10; j++) begin
                    a_cycle(0, '0, 0, hs);
                    check("a_hold", a_out, held);
                end
            end
        end
        check("a_hs_count", n_hs, 1000);
        // Reseed mid-stream with a handshake in the same cycle
        a_cycle(1, rnd128(), 1, hs);
        for (int j = 0; j < W + 40; j++) a_cycle(0, '0, $urandom_range(0, 1), hs);
        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a_sv = 0; a_rdy = 0;
        #2 rst = 1;
        #1;
        check("arst_valid", a_vld, 0);
        check("arst_herr", a_err, 0);
        m_run = 0; m_left = 0; m_err = 0;
        @(negedge clk);
        rst = 0;
        repeat (5) a_cycle(0, '0, 1, hs);
        // All-zero seed
        a_cycle(1, '0, 1, hs);
        for (int j = 0; j < W + 20; j++) a_cycle(0, '0, $urandom_range(0, 1), hs);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
